con_reader: RTL
===============

CON_READER -- requirements
Module: con_reader

Interface
REQ-001 CLK_DIV, 300, clk cycles per half-period of con_clock; legal range 4..65535.
REQ-002 POLL_PERIOD, 833333, clk cycles between scan requests; SHALL exceed 34*CLK_DIV+2.
REQ-003 clk  in  1  single system clock; all logic in this one domain.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 scan_en  in  1  enables periodic scans; level-sensitive.
REQ-006 con_data  in  1  serial controller data, asynchronous, 0 = button pressed.
REQ-007 con_latch  out  1  latch strobe to controller, active-high.
REQ-008 con_clock  out  1  shift clock to controller, idles high.
REQ-009 buttons  out  16  last published button word, 1 = pressed; drives the 16-bit input PIO export of the SoC.
REQ-010 buttons_valid  out  1  one-cycle pulse, coincident with each buttons update.

Function
REQ-011 con_data SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-012 Poll counter SHALL free-run 0..POLL_PERIOD-1 and wrap, regardless of state or scan_en.
REQ-013 States SHALL be IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE.
REQ-014 IDLE -> LATCH SHALL occur on the cycle after poll counter == POLL_PERIOD-1 while scan_en=1; otherwise IDLE is held.
REQ-015 LATCH SHALL last exactly 2*CLK_DIV cycles with con_latch=1, con_clock=1; its last cycle samples bit 0.
REQ-016 SHIFT_LO SHALL last CLK_DIV cycles with con_clock=0; SHIFT_HI SHALL last CLK_DIV cycles with con_clock=1.
REQ-017 Exactly 16 LO/HI pulse pairs per scan; the last cycle of HI phase k (k=1..15) samples bit k; the 16th HI phase samples nothing.
REQ-018 Bit index counter SHALL be 4 bits, reset to 0 at LATCH entry, no wrap beyond 15 within a scan.
REQ-019 After the 16th HI phase, the FSM SHALL enter DONE for exactly one cycle, then IDLE.
REQ-020 The edge entering DONE SHALL load buttons[i] = NOT sampled bit i for i=0..15; buttons_valid=1 during DONE only.
REQ-021 Total scan length LATCH entry to DONE entry SHALL be 34*CLK_DIV cycles.
REQ-022 buttons SHALL hold its value between scans; outputs SHALL not change while scanning except con_latch and con_clock.
REQ-023 Deasserting scan_en mid-scan SHALL NOT abort; the scan completes and publishes.
REQ-024 A poll wrap occurring while not in IDLE SHALL be dropped, not queued.
REQ-025 Outside LATCH, con_latch=0; in IDLE and DONE, con_clock=1.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, poll counter=0, bit index=0, synchronizer=1s, buttons=16'h0000, buttons_valid=0, con_latch=0, con_clock=1.
REQ-027 Reset mid-scan SHALL discard partial data; no buttons_valid pulse for that scan.
REQ-028 After rst_n release, the first LATCH SHALL begin POLL_PERIOD cycles later if scan_en=1.

Verification (CLK_DIV=4, POLL_PERIOD=200)
REQ-029 Model drives bit i of 16'hFFFE (B pressed) -> buttons=16'h0001 with one buttons_valid pulse, 136 cycles after LATCH entry.
REQ-030 Pattern 16'h0F0F (active-low) -> buttons=16'hF0F0; con_clock shows exactly 16 low pulses, each 4 cycles.
REQ-031 scan_en=0 for 1000 cycles -> con_latch stays 0, buttons unchanged, no buttons_valid.
REQ-032 scan_en dropped at bit 7 -> scan completes, buttons updates, next wrap starts no scan.
REQ-033 rst_n asserted at bit 10 -> buttons=0, con_clock=1, con_latch=0 at once; no pulse; next scan after 200 cycles.
REQ-034 Back-to-back scans with changing data -> each scan's buttons_valid spaced exactly 200 cycles, values match per-scan stimulus.

Source files
------------

// File: rtl/con_reader.sv
// Serial game-controller reader: periodically latches and shifts 16 buttons, publishes active-high word.
// Latency: a scan takes 34*CLK_DIV cycles from latch entry; buttons/buttons_valid update on DONE entry.
// Backpressure: none; buttons_valid is a single-cycle pulse and wraps during a scan are dropped.
module con_reader #(
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic        con_data,
    output logic        con_latch,
    output logic        con_clock,
    output logic [15:0] buttons,
    output logic        buttons_valid
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int DW = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [1:0]      sync;
    logic            data_s;
    logic [PW-1:0]   poll_cnt;
    logic            poll_wrap;
    logic [DW-1:0]   div_cnt;
    logic            phase_end;
    logic [3:0]      bit_idx;
    logic [3:0]      next_idx;
    logic [15:0]     sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], con_data};
        end
    end

    assign data_s = sync[1];

    // Free-running poll timebase, independent of FSM and scan_en.
    assign poll_wrap = (poll_cnt == PW'(POLL_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (poll_wrap) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PW'(1);
        end
    end

    assign phase_end = (state == LATCH) ? (div_cnt == DW'(2 * CLK_DIV - 1))
                                        : (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == IDLE || next_state != state) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (poll_wrap && scan_en) next_state = LATCH;
            LATCH:    if (phase_end) next_state = SHIFT_LO;
            SHIFT_LO: if (phase_end) next_state = SHIFT_HI;
            SHIFT_HI: if (phase_end) next_state = (bit_idx == 4'd15) ? DONE : SHIFT_LO;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        con_latch     = (state == LATCH);
        con_clock     = (state != SHIFT_LO);
        buttons_valid = (state == DONE);
    end

    // bit_idx counts completed pulse pairs; the pair with bit_idx==15 is the 16th and samples nothing.
    assign next_idx = bit_idx + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 4'd0;
            sample  <= 16'h0000;
        end else begin
            if (state == IDLE && next_state == LATCH) begin
                bit_idx <= 4'd0;
            end
            if (state == LATCH && phase_end) begin
                sample[0] <= data_s;
            end
            if (state == SHIFT_HI && phase_end && bit_idx != 4'd15) begin
                sample[next_idx] <= data_s;
                bit_idx          <= next_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons <= 16'h0000;
        end else if (state == SHIFT_HI && next_state == DONE) begin
            buttons <= ~sample;
        end
    end

endmodule
